// File: rtl/seq_alu_if.sv
// seq_alu request/result bundle.
// Handshaked operand channel in, registered result channel out.
interface seq_alu_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [5:0]       ctl;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic             busy;

  modport master (
    output in_valid, x, y, ctl, mode, out_ready,
    input  in_ready, out_valid, out, zr, ng, busy
  );

  modport slave (
    input  in_valid, x, y, ctl, mode, out_ready,
    output in_ready, out_valid, out, zr, ng, busy
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: Hack ALU with registered result plus
// iterative unsigned MUL / DIV / REM.
module seq_alu #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input logic clk,
  input logic reset,
  seq_alu_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             no_q, no_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;

  logic [WIDTH-1:0] cx, cy;
  logic [WIDTH-1:0] alu_r, alu_res;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   div_r;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] step_r;
  logic [WIDTH-1:0] step_res;
  logic             last_step;

  // Operand conditioning and single-cycle ALU result
  always_comb begin
    cx = bus.ctl[5] ? '0 : bus.x;
    cx = bus.ctl[4] ? ~cx : cx;
    cy = bus.ctl[3] ? '0 : bus.y;
    cy = bus.ctl[2] ? ~cy : cy;
    alu_r = bus.ctl[1] ? cx + cy : cx & cy;
    alu_res = bus.ctl[0] ? ~alu_r : alu_r;
  end

  // One shift-add (MUL) or restoring shift-subtract (DIV/REM) step
  always_comb begin
    mul_acc = b_q[0] ? acc_q + a_q : acc_q;
    div_r = {acc_q, b_q[WIDTH-1]};
    div_ge = div_r >= {1'b0, a_q};
    div_diff = div_r[WIDTH-1:0] - a_q;
    div_rem = div_ge ? div_diff : div_r[WIDTH-1:0];
    div_q = {b_q[WIDTH-2:0], div_ge};
    unique case (mode_q)
      2'b01:   step_r = mul_acc;
      2'b10:   step_r = div_q;
      default: step_r = div_rem;
    endcase
    step_res = no_q ? ~step_r : step_r;
    last_step = cnt_q == CNT_W'(WIDTH - 1);
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    no_d    = no_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    out_d   = out_q;
    zr_d    = zr_q;
    ng_d    = ng_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          mode_d = bus.mode;
          no_d   = bus.ctl[0];
          a_d    = cy;
          b_d    = cx;
          acc_d  = '0;
          cnt_d  = '0;
          if (bus.mode == 2'b00) begin
            out_d   = alu_res;
            zr_d    = alu_res == '0;
            ng_d    = alu_res[WIDTH-1];
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (mode_q == 2'b01) begin
          acc_d = mul_acc;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
        end else begin
          acc_d = div_rem;
          b_d   = div_q;
        end
        if (last_step) begin
          out_d   = step_res;
          zr_d    = step_res == '0;
          ng_d    = step_res[WIDTH-1];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, reset aborts any operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      no_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      no_q    <= no_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      zr_q    <= zr_d;
      ng_q    <= ng_d;
    end
  end

  assign bus.in_ready  = state_q == S_IDLE;
  assign bus.out_valid = state_q == S_DONE;
  assign bus.busy      = state_q != S_IDLE;
  assign bus.out       = out_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed cases plus random ops
// against an arithmetic reference model.
module tb_seq_alu;

  localparam int W = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(
    input logic [W-1:0] xi,
    input logic [W-1:0] yi,
    input logic [5:0]   c,
    input logic [1:0]   m
  );
    logic [31:0] xv, yv, r;
    xv = c[5] ? 32'd0 : {16'd0, xi};
    if (c[4]) xv = ~xv & 32'hFFFF;
    yv = c[3] ? 32'd0 : {16'd0, yi};
    if (c[2]) yv = ~yv & 32'hFFFF;
    case (m)
      2'd0: r = c[1] ? xv + yv : xv & yv;
      2'd1: r = xv * yv;
      2'd2: r = (yv == 0) ? 32'hFFFF : xv / yv;
      default: r = (yv == 0) ? xv : xv % yv;
    endcase
    if (c[0]) r = ~r;
    return r[W-1:0];
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(
    input logic [W-1:0] xi,
    input logic [W-1:0] yi,
    input logic [5:0]   c,
    input logic [1:0]   m,
    input bit           chk_busy
  );
    int lat;
    logic [W-1:0] e;
    e = model(xi, yi, c, m);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x = xi;
    bus.y = yi;
    bus.ctl = c;
    bus.mode = m;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.x = W'($urandom);
    bus.y = W'($urandom);
    bus.ctl = 6'($urandom);
    bus.mode = 2'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      if (chk_busy) check("in_ready_busy", bus.in_ready, 0);
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, (m == 2'd0) ? 1 : W + 1);
    check("out", bus.out, e);
    check("zr", bus.zr, e == 0);
    check("ng", bus.ng, e[W-1]);
  endtask

  task automatic finish_op;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("valid_drop", bus.out_valid, 0);
    check("ready_back", bus.in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] hold_out;
    logic         hold_zr;
    logic         hold_ng;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.ctl = '0;
    bus.mode = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_out", bus.out, 0);
    check("rst_zr", bus.zr, 0);
    check("rst_ng", bus.ng, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.in_ready, 1);

    do_op(16'd5, 16'd3, 6'b000010, 2'd0, 1'b0);
    check("alu_add", bus.out, 16'd8);
    finish_op();
    do_op(16'd5, 16'd3, 6'b101010, 2'd0, 1'b0);
    check("alu_zero", bus.zr, 1);
    finish_op();

    do_op(16'd300, 16'd300, 6'b000000, 2'd1, 1'b1);
    check("mul_300", bus.out, 16'h5F90);
    check("mul_busy", bus.busy, 1);
    finish_op();

    do_op(16'd100, 16'd7, 6'b000000, 2'd2, 1'b1);
    check("div_100_7", bus.out, 16'd14);
    finish_op();
    do_op(16'd100, 16'd7, 6'b000000, 2'd3, 1'b1);
    check("rem_100_7", bus.out, 16'd2);
    finish_op();

    do_op(16'd1234, 16'd0, 6'b000000, 2'd2, 1'b0);
    check("div0_q", bus.out, 16'hFFFF);
    check("div0_ng", bus.ng, 1);
    finish_op();
    do_op(16'd1234, 16'd0, 6'b000000, 2'd3, 1'b0);
    check("div0_r", bus.out, 16'd1234);
    finish_op();

    do_op(16'h8001, 16'h0002, 6'b000010, 2'd0, 1'b0);
    hold_out = 16'h8003;
    hold_zr = 1'b0;
    hold_ng = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.x = 16'd9;
      bus.y = 16'd9;
      bus.ctl = 6'b000010;
      bus.mode = 2'd0;
      @(posedge clk);
      #1;
      check("bp_out", bus.out, hold_out);
      check("bp_zr", bus.zr, hold_zr);
      check("bp_ng", bus.ng, hold_ng);
      check("bp_valid", bus.out_valid, 1);
      check("bp_ready", bus.in_ready, 0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    finish_op();
    check("hold_idle", bus.out, hold_out);

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x = 16'd300;
    bus.y = 16'd300;
    bus.ctl = 6'b000000;
    bus.mode = 2'd1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_out", bus.out, 0);
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ready", bus.in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    do_op(16'd20, 16'd22, 6'b000010, 2'd0, 1'b0);
    check("post_rst_alu", bus.out, 16'd42);
    finish_op();

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] rx, ry;
      logic [5:0]   rc;
      logic [1:0]   rm;
      rx = W'($urandom);
      ry = (i % 8 == 3) ? W'(0) : W'($urandom_range(0, 300));
      if (i % 5 == 1) ry = W'($urandom);
      rc = 6'($urandom);
      rm = 2'($urandom);
      do_op(rx, ry, rc, rm, 1'b1);
      finish_op();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, handshaked successor to the combinational Hack ALU. It keeps the Hack six-bit control semantics (zx, nx, zy, ny, f, no) at WIDTH bits with a registered result. It adds multi-cycle unsigned multiply, divide and remainder modes. It sits between the CPU datapath and the register file, where a core needs MUL/DIV without adding combinational depth.

Parameters:
- WIDTH, 16: datapath width in bits, minimum 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width, derived; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation this cycle.
- x  in  WIDTH  operand x.
- y  in  WIDTH  operand y.
- ctl  in  6  {zx,nx,zy,ny,f,no}, with ctl[5]=zx and ctl[0]=no.
- mode  in  2  00 ALU, 01 MUL, 10 DIV (quotient), 11 REM (remainder).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out  out  WIDTH  result.
- zr  out  1  out == 0.
- ng  out  1  out[WIDTH-1].
- busy  out  1  high in BUSY and DONE.

Behaviour:
- Reset: a single clock and a synchronous, active-high reset. On a reset-high edge the block enters IDLE and forces out=0, zr=0, ng=0, out_valid=0, busy=0. in_ready reads 1 in the first cycle after reset.
- Reset mid-operation: any in-flight MUL/DIV is aborted and the pending result is discarded. Reset has priority over all other inputs.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready. x, y, ctl and mode are registered at that edge only. Later input changes are ignored until the next accept.
- Operand conditioning applies in every mode. X = zx ? 0 : x, then X = nx ? ~X : X. The same applies to Y with zy and ny.
- ALU mode: R = f ? X+Y (mod 2^WIDTH) : X&Y. Result = no ? ~R : R.
- MUL mode: R = low WIDTH bits of X*Y, unsigned. Result = no ? ~R : R. f is ignored.
- DIV and REM modes: unsigned restoring division, X / Y. DIV returns the quotient, REM returns the remainder. f is ignored; no inverts the result.
- Divide by zero (Y==0): quotient is all ones and remainder is X. No error flag is raised.
- States:
  - IDLE: in_ready=1, out_valid=0. On accept with mode 00, go to DONE. On accept with any other mode, go to BUSY with counter=0.
  - BUSY: in_ready=0. Performs one shift-add or shift-subtract step per cycle. After exactly WIDTH steps the result is written to out and the state goes to DONE.
  - DONE: out_valid=1, in_ready=0. On an edge with out_ready=1, go to IDLE and drop out_valid.
- Latency, counted from the accept edge:
  - ALU: out_valid is high after 1 edge.
  - MUL, DIV, REM: out_valid is high after WIDTH+1 edges.
- Throughput: the next accept can happen no earlier than the cycle after the result handshake. There is no back-to-back overlap; minimum 2 cycles per ALU op.
- Output hold: out, zr and ng are registered and change only when entering DONE. They are stable while out_valid && !out_ready. They keep their last value after returning to IDLE.
- Flags: zr and ng are registered together with out and always describe the current out.
- in_valid while in_ready=0 has no effect; the requester must hold the request.

Test Plan:
- WIDTH=16, ALU, x=5, y=3, ctl=000010 -> one edge after accept: out=8, zr=0, ng=0, out_valid=1. With ctl=101010 -> out=0, zr=1.
- MUL, x=300, y=300, ctl=000000 -> out_valid exactly 17 edges after accept, out=0x5F90 (24464), zr=0. in_ready=0 throughout.
- DIV, x=100, y=7 -> out=14. REM with the same operands -> out=2. Both after 17 edges.
- Divide by zero: DIV, x=1234, y=0 -> out=0xFFFF, ng=1. REM -> out=1234.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out, zr and ng stay constant and in_valid is ignored. Pulsing out_ready=1 gives out_valid=0 and in_ready=1 on the next cycle.
- Reset mid-op: assert reset 6 cycles into a MUL -> next cycle IDLE, out=0, out_valid=0, busy=0. A new ALU op then completes correctly.
